// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR tap engine: one sample in, TAPS serial multiply-accumulates
// through a single multiplier, then one saturated Q1.(N-1) output sample.
module fir_mac_seq #(
  parameter int unsigned N     = 16,
  parameter int unsigned TAPS  = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned ACC_W = 34
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic [N-1:0]  din,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [N-1:0]  coef_data,
  output logic          coef_drop,
  output logic [N-1:0]  dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sat
);

  localparam logic signed [ACC_W-1:0] P_MAX = $signed({{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] P_MIN = $signed({{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}});

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                  r_state;
  logic signed [N-1:0]     r_x [TAPS];
  logic signed [N-1:0]     r_c [TAPS];
  logic signed [ACC_W-1:0] r_acc;
  logic [AW-1:0]           r_idx;

  logic signed [2*N-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic signed [ACC_W-1:0] w_shr;
  logic                    w_pos_ovf;
  logic                    w_neg_ovf;
  logic                    w_coef_hit;
  logic                    w_last;

  assign in_ready = (r_state == IDLE);

  // Single shared multiplier; product is sign-extended into the accumulator.
  assign w_prod     = (2*N)'(r_x[r_idx]) * (2*N)'(r_c[r_idx]);
  assign w_acc_nxt  = r_acc + {{(ACC_W-2*N){w_prod[2*N-1]}}, w_prod};
  assign w_shr      = w_acc_nxt >>> (N-1);
  assign w_pos_ovf  = (w_shr > P_MAX);
  assign w_neg_ovf  = (w_shr < P_MIN);
  assign w_coef_hit = coef_we && ({1'b0, coef_addr} < (AW+1)'(TAPS));
  assign w_last     = (r_idx == AW'(TAPS-1));

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_idx     <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      sat       <= 1'b0;
      coef_drop <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        r_x[k] <= '0;
        r_c[k] <= '0;
      end
    end else begin
      coef_drop <= coef_we && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (w_coef_hit) r_c[coef_addr] <= coef_data;
          if (in_valid) begin
            r_x[0] <= din;
            for (int k = 1; k < TAPS; k++) r_x[k] <= r_x[k-1];
            r_acc   <= '0;
            r_idx   <= '0;
            r_state <= MAC;
          end
        end
        MAC: begin
          r_acc <= w_acc_nxt;
          r_idx <= r_idx + AW'(1);
          // Result is saturated and registered on the same edge as the last product.
          if (w_last) begin
            r_state   <= OUT;
            out_valid <= 1'b1;
            if (w_pos_ovf) begin
              dout <= {1'b0, {(N-1){1'b1}}};
              sat  <= 1'b1;
            end else if (w_neg_ovf) begin
              dout <= {1'b1, {(N-1){1'b0}}};
              sat  <= 1'b1;
            end else begin
              dout <= w_shr[N-1:0];
              sat  <= 1'b0;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: arithmetic FIR model with an expected-output queue,
// checked every cycle, plus hand-computed literal expectations.
module tb_fir_mac_seq;
  localparam int unsigned N     = 16;
  localparam int unsigned TAPS  = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned ACC_W = 34;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  din = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [N-1:0]  coef_data = '0;
  logic          coef_drop;
  logic [N-1:0]  dout;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          sat;

  always #5 CLK = ~CLK;

  fir_mac_seq #(.N(N), .TAPS(TAPS), .AW(AW), .ACC_W(ACC_W)) dut (
    .CLK(CLK), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_drop(coef_drop), .dout(dout), .out_valid(out_valid),
    .out_ready(out_ready), .sat(sat)
  );

  typedef struct {
    logic [N-1:0] d;
    logic         s;
    int           edge_n;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic prev_ov = 1'b0;
  exp_t q[$];
  logic signed [N-1:0] mx [TAPS];
  logic signed [N-1:0] mc [TAPS];
  logic [N-1:0] got_d;
  logic         got_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) begin
      mx[k] = '0;
      mc[k] = '0;
    end
    q.delete();
  endtask

  // FIR arithmetic on the delay line, floor-shift, clip to the Q1.(N-1) range.
  task automatic model_accept(input logic [N-1:0] d);
    longint acc;
    longint r;
    exp_t   e;
    for (int k = TAPS-1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = d;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += longint'(mx[k]) * longint'(mc[k]);
    r = acc >>> (N-1);
    if (r > 32767) begin
      e.d = 16'h7FFF; e.s = 1'b1;
    end else if (r < -32768) begin
      e.d = 16'h8000; e.s = 1'b1;
    end else begin
      e.d = r[N-1:0]; e.s = 1'b0;
    end
    e.edge_n = cyc + 1;
    q.push_back(e);
  endtask

  // Advance one clock and compare every DUT output against the model.
  task automatic tick();
    logic hs;
    logic pend;
    hs   = out_valid && out_ready;
    pend = coef_we && !in_ready;
    @(negedge CLK);
    cyc++;
    if (hs && q.size() > 0) void'(q.pop_front());
    chk("coef_drop", 32'(coef_drop), 32'(pend));
    if (out_valid) begin
      chk("in_ready_in_out", 32'(in_ready), 32'(0));
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_out: got out_valid=1 dout=0x%0h expected no output (cycle %0d)", dout, cyc);
      end else begin
        chk("dout", 32'(dout), 32'(q[0].d));
        chk("sat", 32'(sat), 32'(q[0].s));
        if (!prev_ov) chk("latency", 32'(cyc - q[0].edge_n), 32'(TAPS));
      end
    end
    prev_ov = out_valid;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
    model_clear();
    tick();
    tick();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (in_ready) break;
      tick();
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: got in_ready=0 expected 1 (cycle %0d)", cyc);
    end
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [N-1:0] d);
    wait_idle();
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    if ({1'b0, a} < (AW+1)'(TAPS)) mc[a] = d;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic send(input logic [N-1:0] d, input logic we,
                      input logic [AW-1:0] a, input logic [N-1:0] cd);
    din = d; in_valid = 1'b1;
    wait_idle();
    if (in_ready) begin
      coef_we = we; coef_addr = a; coef_data = cd;
      if (we && ({1'b0, a} < (AW+1)'(TAPS))) mc[a] = cd;
      model_accept(d);
    end
    tick();
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic wait_out(output logic [N-1:0] d, output logic s);
    for (int i = 0; i < 40; i++) begin
      if (out_valid) break;
      tick();
    end
    if (!out_valid) begin
      n_tests++; n_fail++;
      $display("FAIL out_timeout: got out_valid=0 expected 1 (cycle %0d)", cyc);
    end
    d = dout;
    s = sat;
  endtask

  initial begin
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_dout", 32'(dout), 32'(0));
    chk("rst_sat", 32'(sat), 32'(0));
    chk("rst_coef_drop", 32'(coef_drop), 32'(0));

    // Impulse-style coefficients
    write_coef(2'd0, 16'h4000);
    write_coef(2'd1, 16'h2000);
    send(16'h2000, 1'b0, 2'd0, 16'h0);
    wait_out(got_d, got_s);
    chk("imp1_dout", 32'(got_d), 32'h1000);
    chk("imp1_sat", 32'(got_s), 32'(0));
    send(16'h4000, 1'b0, 2'd0, 16'h0);
    wait_out(got_d, got_s);
    chk("imp2_dout", 32'(got_d), 32'h2800);
    chk("imp2_sat", 32'(got_s), 32'(0));

    // Positive saturation
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(AW'(k), 16'h7FFF);
    send(16'h7FFF, 1'b0, 2'd0, 16'h0);
    wait_out(got_d, got_s);
    chk("pos1_dout", 32'(got_d), 32'h7FFE);
    chk("pos1_sat", 32'(got_s), 32'(0));
    send(16'h7FFF, 1'b0, 2'd0, 16'h0);
    send(16'h7FFF, 1'b0, 2'd0, 16'h0);
    send(16'h7FFF, 1'b0, 2'd0, 16'h0);
    wait_out(got_d, got_s);
    chk("pos4_dout", 32'(got_d), 32'h7FFF);
    chk("pos4_sat", 32'(got_s), 32'(1));

    // Negative saturation
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(AW'(k), 16'h8000);
    send(16'h7FFF, 1'b0, 2'd0, 16'h0);
    wait_out(got_d, got_s);
    chk("neg1_dout", 32'(got_d), 32'h8001);
    chk("neg1_sat", 32'(got_s), 32'(0));
    send(16'h7FFF, 1'b0, 2'd0, 16'h0);
    wait_out(got_d, got_s);
    chk("neg2_dout", 32'(got_d), 32'h8000);
    chk("neg2_sat", 32'(got_s), 32'(1));
    send(16'h7FFF, 1'b0, 2'd0, 16'h0);
    send(16'h7FFF, 1'b0, 2'd0, 16'h0);
    wait_out(got_d, got_s);
    chk("neg4_dout", 32'(got_d), 32'h8000);
    chk("neg4_sat", 32'(got_s), 32'(1));

    // Backpressure in OUT with a pending sample upstream
    do_reset();
    write_coef(2'd0, 16'h4000);
    write_coef(2'd1, 16'h2000);
    out_ready = 1'b0;
    send(16'h2000, 1'b0, 2'd0, 16'h0);
    wait_out(got_d, got_s);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; din = 16'h7777;
      tick();
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      chk("bp_out_valid", 32'(out_valid), 32'(1));
      chk("bp_dout", 32'(dout), 32'h1000);
      chk("bp_sat", 32'(sat), 32'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_ov", 32'(out_valid), 32'(0));
    chk("bp_release_ir", 32'(in_ready), 32'(1));
    send(16'h4000, 1'b0, 2'd0, 16'h0);
    wait_out(got_d, got_s);
    chk("bp_next_dout", 32'(got_d), 32'h2800);

    // Coefficient write during MAC is dropped
    send(16'h2000, 1'b0, 2'd0, 16'h0);
    coef_we = 1'b1; coef_addr = 2'd1; coef_data = 16'h1234;
    tick();
    coef_we = 1'b0;
    chk("lock_drop_hi", 32'(coef_drop), 32'(1));
    tick();
    chk("lock_drop_lo", 32'(coef_drop), 32'(0));
    wait_out(got_d, got_s);
    chk("lock_dout", 32'(got_d), 32'h2000);

    // Coefficient write together with sample acceptance uses the new value
    send(16'h0000, 1'b1, 2'd1, 16'h1234);
    wait_out(got_d, got_s);
    chk("simul_dout", 32'(got_d), 32'h048D);
    chk("simul_sat", 32'(got_s), 32'(0));

    // Reset on the second MAC cycle
    wait_idle();
    send(16'h7FFF, 1'b0, 2'd0, 16'h0);
    tick();
    rst = 1'b1;
    model_clear();
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    for (int i = 0; i < 10; i++) tick();
    write_coef(2'd0, 16'h4000);
    send(16'h2000, 1'b0, 2'd0, 16'h0);
    wait_out(got_d, got_s);
    chk("mid_rst_dout", 32'(got_d), 32'h1000);
    chk("mid_rst_sat", 32'(got_s), 32'(0));
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
